chess_turn_ctrl: RTL and testbench
==================================

// Module: chess_turn_ctrl
// PURPOSE
//  Initiator-side controller for the two-player chess clock counter block.
//  Turns player buttons, start and a time preset into the counter's control pulses:
//  enload, count1, count2 and load_val.
//  Watches the counter's fin flag to end the game and report the winner.
//  Never asserts count1 and count2 together; the counter treats that as "hold".
// PARAMETERS
//  W        8  width of time preset / load_val (matches counter in/out width)
//  TICK_DIV 4  clk cycles per count pulse (>=2); 1 pulse = 1 time unit
// PORTS
//  clk       in   1  system clock, all logic on posedge
//  reset     in   1  asynchronous, active-high; clears all state
//  start     in   1  level; rising edge starts or restarts a game
//  btn1      in   1  player-1 move-done button, level; rising edge used
//  btn2      in   1  player-2 move-done button, level; rising edge used
//  pause     in   1  rising edge toggles pause (only with CHESS_PAUSE_EN)
//  time_in   in   W  per-player time preset, sampled on accepted start
//  fin       in   1  from counter: a player's time reached 0 (registered)
//  enload    out  1  one-cycle load strobe to counter
//  load_val  out  W  value to load, valid while enload=1
//  count1    out  1  one-cycle decrement pulse, player-1 counter
//  count2    out  1  one-cycle decrement pulse, player-2 counter
//  state_o   out  3  current FSM state encoding
//  winner    out  2  00 none, 01 player 1, 10 player 2; valid in DONE
// BEHAVIOUR
//  Reset: state IDLE; enload, count1, count2, load_val, winner = 0; edge detectors cleared.
//  Edge detect: one flop per button and start; event = in & ~in_q. Level held = one event.
//  FSM: IDLE, LOAD, SETTLE, RUN_P1, RUN_P2, PAUSE, DONE.
//  IDLE: start edge with time_in!=0 -> LOAD; start with time_in==0 ignored.
//  LOAD (1 cycle): enload=1, load_val=time_in latched; winner<=0 -> SETTLE.
//  SETTLE (2 cycles): fin ignored (stale for 2 cycles after load) -> RUN_P1.
//  RUN_P1: prescaler counts; count1=1 for 1 cycle when it wraps at TICK_DIV-1.
//    btn1 edge -> RUN_P2, prescaler cleared; btn2 ignored.
//  RUN_P2: mirror of RUN_P1 with count2 / btn2 -> RUN_P1.
//  fin=1 in RUN_Px -> DONE; winner = other player (RUN_P1 -> 10, RUN_P2 -> 01).
//  Simultaneous fin and own button in same cycle: fin wins -> DONE.
//  Count pulse and turn switch in same cycle: pulse still issued, then switch.
//  DONE: all strobes 0, winner held; start edge -> LOAD (new game).
//  Start edge in any RUN/PAUSE state: abort, go to LOAD, winner cleared.
//  Latency: button edge at cycle n -> state change at n+1 -> first pulse of
//    the new player at n+1+TICK_DIV.
//  Prescaler: $clog2(TICK_DIV) bits; wraps to 0; held at 0 outside RUN states.
//  Async reset mid-game: immediate return to IDLE, strobes drop without waiting for clk.
// CONFIGURATION
//  CHESS_PAUSE_EN defined: pause edge in RUN_Px -> PAUSE (turn remembered,
//    prescaler frozen, no pulses); pause edge in PAUSE -> saved RUN_Px.
//    Buttons ignored in PAUSE; start still restarts.
//  Not defined: pause port absent, PAUSE state unreachable, encoding unchanged.
// STRUCTURE
//  chess_pkg: state encodings (ST_IDLE..ST_DONE), winner codes (WIN_NONE/P1/P2).
//  Sub-module chess_tick_gen: prescaler with clr/en inputs, tick output.
//  Three edge detectors and the FSM stay in this module.
// TESTING
//  1 start, time_in=3 -> enload 1 cycle, load_val=3; RUN_P1; count1 every 4 clks.
//  2 RUN_P1, btn1 held 10 cycles -> exactly one switch to RUN_P2; only count2 pulses after.
//  3 Paired with counter, time_in=2, no buttons -> fin -> DONE, winner=10.
//  4 fin and btn2 same cycle in RUN_P2 -> DONE, winner=01, no RUN_P1 entry.
//  5 start with time_in=0 -> stays IDLE, enload never asserted.
//  6 With CHESS_PAUSE_EN: pause in RUN_P2 for 20 clks -> no pulses; resume -> RUN_P2.
//    Also: async reset mid-RUN -> IDLE, all outputs 0.

Source files
------------

// File: rtl/chess_turn_ctrl_pkg.sv
// chess_pkg: shared types and codes for the chess clock turn controller.
//   state_t  : FSM state encoding, also exported on state_o
//   WIN_*    : winner codes
//   is_run() : true in either player's running state
package chess_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_SETTLE = 3'd2,
      ST_RUN_P1 = 3'd3,
      ST_RUN_P2 = 3'd4,
      ST_PAUSE  = 3'd5,
      ST_DONE   = 3'd6
   } state_t;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;

   function automatic logic is_run(input state_t s);
      return (s == ST_RUN_P1) || (s == ST_RUN_P2);
   endfunction

endpackage

// File: rtl/chess_turn_ctrl_if.sv
// Signal bundle between the turn controller and its environment
// (player buttons, start/preset, counter block).
//   master : the controller (drives enload/load_val/count1/count2/state_o/winner)
//   slave  : the environment (drives start/btn1/btn2/time_in/fin, pause if enabled)
// Macro CHESS_PAUSE_EN adds the pause signal.
interface chess_turn_ctrl_if #(parameter int W = 8) ();
`ifdef CHESS_PAUSE_EN
   logic         pause;
`endif
   logic         start;
   logic         btn1;
   logic         btn2;
   logic [W-1:0] time_in;
   logic         fin;
   logic         enload;
   logic [W-1:0] load_val;
   logic         count1;
   logic         count2;
   logic [2:0]   state_o;
   logic [1:0]   winner;

   modport master (
`ifdef CHESS_PAUSE_EN
      input  pause,
`endif
      input  start, btn1, btn2, time_in, fin,
      output enload, load_val, count1, count2, state_o, winner
   );

   modport slave (
`ifdef CHESS_PAUSE_EN
      output pause,
`endif
      output start, btn1, btn2, time_in, fin,
      input  enload, load_val, count1, count2, state_o, winner
   );
endinterface

// File: rtl/chess_turn_ctrl_tick_gen.sv
// chess_tick_gen: prescaler producing one tick every TICK_DIV enabled cycles.
//   i_clk, i_reset : clock, async active-high reset
//   i_clr          : synchronous clear to 0 (wins over i_en)
//   i_en           : advance the prescaler
//   o_tick         : high in the enabled cycle where the prescaler wraps
module chess_tick_gen #(
   parameter int TICK_DIV = 4
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tick
);
   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

   logic [CW-1:0] r_cnt;

   assign o_tick = i_en && (r_cnt == CNT_MAX);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
      end
   end
endmodule

// File: rtl/chess_turn_ctrl.sv
// chess_turn_ctrl: turn controller for a two-player chess clock counter.
// Converts start/buttons/preset into enload, load_val, count1, count2 pulses
// and ends the game on the counter's fin flag, reporting the winner.
//   i_clk, i_reset : clock, async active-high reset
//   ctrl_bus       : chess_turn_ctrl_if.master (start, btn1, btn2, time_in, fin,
//                    enload, load_val, count1, count2, state_o, winner)
// Optional macro CHESS_PAUSE_EN enables the pause input and PAUSE state.
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | waiting for a start edge with a non-zero preset
// LOAD      | one-cycle enload with the latched preset
// SETTLE    | two cycles, fin is stale after a load and is ignored
// RUN_P1    | player 1 clock running (count1 pulses)
// RUN_P2    | player 2 clock running (count2 pulses)
// PAUSE     | frozen, turn remembered (CHESS_PAUSE_EN only)
// DONE      | a clock expired, winner held
module chess_turn_ctrl
   import chess_pkg::*;
#(
   parameter int W        = 8,
   parameter int TICK_DIV = 4
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   chess_turn_ctrl_if.master    ctrl_bus
);

   state_t         r_state;
   state_t         w_state_nxt;
   logic           r_start_q;
   logic           r_btn1_q;
   logic           r_btn2_q;
   logic           w_start_ev;
   logic           w_btn1_ev;
   logic           w_btn2_ev;
   logic           w_start_ok;
   logic           r_settle_cnt;
   logic [W-1:0]   r_load_val;
   logic [1:0]     r_winner;
   logic           r_count1;
   logic           r_count2;
   logic           w_tick;
   logic           w_tick_en;
   logic           w_tick_clr;
`ifdef CHESS_PAUSE_EN
   logic           r_pause_q;
   logic           w_pause_ev;
   logic           r_resume_p2;
`endif

   assign w_start_ev = ctrl_bus.start & ~r_start_q;
   assign w_btn1_ev  = ctrl_bus.btn1  & ~r_btn1_q;
   assign w_btn2_ev  = ctrl_bus.btn2  & ~r_btn2_q;
   // A zero preset would end the game immediately, so such starts are dropped
   // in every state that accepts a start.
   assign w_start_ok = w_start_ev && (ctrl_bus.time_in != '0);
`ifdef CHESS_PAUSE_EN
   assign w_pause_ev = ctrl_bus.pause & ~r_pause_q;
`endif

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_start_q <= 1'b0;
         r_btn1_q  <= 1'b0;
         r_btn2_q  <= 1'b0;
`ifdef CHESS_PAUSE_EN
         r_pause_q <= 1'b0;
`endif
      end else begin
         r_start_q <= ctrl_bus.start;
         r_btn1_q  <= ctrl_bus.btn1;
         r_btn2_q  <= ctrl_bus.btn2;
`ifdef CHESS_PAUSE_EN
         r_pause_q <= ctrl_bus.pause;
`endif
      end
   end

   // Priority inside RUN: restart, then fin, then pause, then own button.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_start_ok) w_state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            w_state_nxt = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (r_settle_cnt == 1'b0) w_state_nxt = ST_RUN_P1;
         end
         ST_RUN_P1: begin
            if (w_start_ok)          w_state_nxt = ST_LOAD;
            else if (ctrl_bus.fin)   w_state_nxt = ST_DONE;
`ifdef CHESS_PAUSE_EN
            else if (w_pause_ev)     w_state_nxt = ST_PAUSE;
`endif
            else if (w_btn1_ev)      w_state_nxt = ST_RUN_P2;
         end
         ST_RUN_P2: begin
            if (w_start_ok)          w_state_nxt = ST_LOAD;
            else if (ctrl_bus.fin)   w_state_nxt = ST_DONE;
`ifdef CHESS_PAUSE_EN
            else if (w_pause_ev)     w_state_nxt = ST_PAUSE;
`endif
            else if (w_btn2_ev)      w_state_nxt = ST_RUN_P1;
         end
`ifdef CHESS_PAUSE_EN
         ST_PAUSE: begin
            if (w_start_ok)          w_state_nxt = ST_LOAD;
            else if (w_pause_ev)     w_state_nxt = r_resume_p2 ? ST_RUN_P2 : ST_RUN_P1;
         end
`endif
         ST_DONE: begin
            if (w_start_ok) w_state_nxt = ST_LOAD;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // The prescaler only advances while play continues into a RUN state, so a
   // wrap coinciding with fin, restart or pause produces no stray pulse.
   // A pause freezes it; a turn switch restarts it for the new player.
   always_comb begin
      w_tick_en  = is_run(r_state) && is_run(w_state_nxt);
      w_tick_clr = !(is_run(r_state) || (r_state == ST_PAUSE))
                   || ((r_state == ST_RUN_P1) && (w_state_nxt == ST_RUN_P2))
                   || ((r_state == ST_RUN_P2) && (w_state_nxt == ST_RUN_P1));
   end

   chess_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_clr   (w_tick_clr),
      .i_en    (w_tick_en),
      .o_tick  (w_tick)
   );

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state      <= ST_IDLE;
         r_settle_cnt <= 1'b0;
         r_load_val   <= '0;
         r_winner     <= WIN_NONE;
         r_count1     <= 1'b0;
         r_count2     <= 1'b0;
`ifdef CHESS_PAUSE_EN
         r_resume_p2  <= 1'b0;
`endif
      end else begin
         r_state  <= w_state_nxt;
         // Registered pulses: a wrap in the switch cycle still reaches the counter.
         r_count1 <= w_tick && (r_state == ST_RUN_P1);
         r_count2 <= w_tick && (r_state == ST_RUN_P2);

         if (r_state == ST_LOAD)
            r_settle_cnt <= 1'b1;
         else if ((r_state == ST_SETTLE) && r_settle_cnt)
            r_settle_cnt <= 1'b0;

         if (w_state_nxt == ST_LOAD)
            r_load_val <= ctrl_bus.time_in;

         if (w_state_nxt == ST_LOAD)
            r_winner <= WIN_NONE;
         else if ((w_state_nxt == ST_DONE) && (r_state == ST_RUN_P1))
            r_winner <= WIN_P2;
         else if ((w_state_nxt == ST_DONE) && (r_state == ST_RUN_P2))
            r_winner <= WIN_P1;
`ifdef CHESS_PAUSE_EN
         if ((w_state_nxt == ST_PAUSE) && is_run(r_state))
            r_resume_p2 <= (r_state == ST_RUN_P2);
`endif
      end
   end

   assign ctrl_bus.enload   = (r_state == ST_LOAD);
   assign ctrl_bus.load_val = (r_state == ST_LOAD) ? r_load_val : '0;
   assign ctrl_bus.count1   = r_count1;
   assign ctrl_bus.count2   = r_count2;
   assign ctrl_bus.state_o  = r_state;
   assign ctrl_bus.winner   = r_winner;

endmodule

// File: tb/tb_chess_turn_ctrl.sv
module tb_chess_turn_ctrl;
   localparam int W = 8;
   localparam int EV_LOAD = 0;
   localparam int EV_C1   = 1;
   localparam int EV_C2   = 2;
   localparam int S_IDLE = 0, S_LOAD = 1, S_RUN1 = 3, S_RUN2 = 4, S_PAUSE = 5, S_DONE = 6;

   typedef struct {
      int kind;
      int val;
      int cyc;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic fin_force = 1'b0;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_err = 0;
   ev_t  exp_q[$];

   logic [W-1:0] m_p1, m_p2;
   logic         m_fin;

   chess_turn_ctrl_if #(.W(W)) bus ();

   chess_turn_ctrl #(.W(W), .TICK_DIV(4)) dut (
      .i_clk    (clk),
      .i_reset  (rst),
      .ctrl_bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Behavioural model of the two-player counter: registered fin.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_p1 <= '0; m_p2 <= '0; m_fin <= 1'b0;
      end else begin
         if (bus.enload) begin
            m_p1 <= bus.load_val; m_p2 <= bus.load_val;
         end else begin
            if (bus.count1 && !bus.count2 && m_p1 != 0) m_p1 <= m_p1 - 1'b1;
            if (bus.count2 && !bus.count1 && m_p2 != 0) m_p2 <= m_p2 - 1'b1;
         end
         m_fin <= (m_p1 == 0) || (m_p2 == 0);
      end
   end
   assign bus.fin = m_fin | fin_force;

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic sb_push(input int kind, input int val, input int c);
      ev_t e;
      e.kind = kind; e.val = val; e.cyc = c;
      exp_q.push_back(e);
   endtask

   task automatic sb_match(input int kind, input int val);
      ev_t e;
      if (exp_q.size() == 0) begin
         chk("unexpected_strobe", kind, -1);
      end else begin
         e = exp_q.pop_front();
         chk("ev_kind", kind, e.kind);
         chk("ev_cyc", cyc, e.cyc);
         chk("ev_val", val, e.val);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.enload) sb_match(EV_LOAD, int'(bus.load_val));
         if (bus.count1) sb_match(EV_C1, 0);
         if (bus.count2) sb_match(EV_C2, 0);
         if (bus.count1 && bus.count2) chk("count_both", 1, 0);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) step(1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.start = 0; bus.btn1 = 0; bus.btn2 = 0; bus.time_in = '0;
`ifdef CHESS_PAUSE_EN
      bus.pause = 0;
`endif
      fin_force = 0;
      step(2);
      exp_q.delete();
      rst = 1'b0;
      step(1);
   endtask

   task automatic start_game(input int t, output int k);
      k = cyc;
      sb_push(EV_LOAD, t, k + 1);
      bus.time_in = W'(t);
      bus.start = 1;
      step(2);
      bus.start = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int k;
      do_reset();
      chk("rst_state", int'(bus.state_o), S_IDLE);
      chk("rst_enload", int'(bus.enload), 0);
      chk("rst_count1", int'(bus.count1), 0);
      chk("rst_count2", int'(bus.count2), 0);
      chk("rst_loadval", int'(bus.load_val), 0);
      chk("rst_winner", int'(bus.winner), 0);

      // Preset 3, no buttons: count1 every 4 clocks, then player 1 runs out.
      start_game(3, k);
      sb_push(EV_C1, 0, k + 8); sb_push(EV_C1, 0, k + 12); sb_push(EV_C1, 0, k + 16);
      wait_until(k + 5);  chk("t1_run1", int'(bus.state_o), S_RUN1);
      wait_until(k + 18); chk("t1_still_run", int'(bus.state_o), S_RUN1);
      wait_until(k + 19); chk("t1_done", int'(bus.state_o), S_DONE);
      chk("t1_winner", int'(bus.winner), 2);
      wait_until(k + 22); chk("t1_done_hold", int'(bus.state_o), S_DONE);
      chk("t1_drain", exp_q.size(), 0);

      // Restart from DONE with preset 2.
      start_game(2, k);
      sb_push(EV_C1, 0, k + 8); sb_push(EV_C1, 0, k + 12);
      chk("t3_winner_clr", int'(bus.winner), 0);
      wait_until(k + 14); chk("t3_run", int'(bus.state_o), S_RUN1);
      wait_until(k + 15); chk("t3_done", int'(bus.state_o), S_DONE);
      chk("t3_winner", int'(bus.winner), 2);
      chk("t3_drain", exp_q.size(), 0);

      // Held button gives one switch; pulse+switch in the same cycle; async reset.
      do_reset();
      start_game(50, k);
      sb_push(EV_C1, 0, k + 8); sb_push(EV_C1, 0, k + 12);
      wait_until(k + 9);  bus.btn2 = 1;
      wait_until(k + 10); bus.btn2 = 0;
      chk("t2_btn2_ignored", int'(bus.state_o), S_RUN1);
      wait_until(k + 13); bus.btn1 = 1;
      sb_push(EV_C2, 0, k + 18); sb_push(EV_C2, 0, k + 22);
      sb_push(EV_C2, 0, k + 26); sb_push(EV_C2, 0, k + 30);
      wait_until(k + 14); chk("t2_run2", int'(bus.state_o), S_RUN2);
      wait_until(k + 23); bus.btn1 = 0;
      chk("t2_one_switch", int'(bus.state_o), S_RUN2);
      wait_until(k + 29); bus.btn2 = 1;
      sb_push(EV_C1, 0, k + 34);
      wait_until(k + 30); chk("t2_back_run1", int'(bus.state_o), S_RUN1);
      wait_until(k + 32); bus.btn2 = 0;
      wait_until(k + 34);
      @(negedge clk); #1;
      rst = 1'b1; #1;
      chk("arst_state", int'(bus.state_o), S_IDLE);
      chk("arst_count1", int'(bus.count1), 0);
      chk("arst_count2", int'(bus.count2), 0);
      chk("arst_enload", int'(bus.enload), 0);
      chk("arst_winner", int'(bus.winner), 0);
      chk("t2_drain", exp_q.size(), 0);

      // fin and btn2 in the same cycle: fin wins, player 1 wins.
      do_reset();
      start_game(50, k);
      wait_until(k + 5);  bus.btn1 = 1;
      sb_push(EV_C2, 0, k + 10);
      wait_until(k + 7);  bus.btn1 = 0;
      wait_until(k + 12); fin_force = 1; bus.btn2 = 1;
      wait_until(k + 13); chk("t4_done", int'(bus.state_o), S_DONE);
      chk("t4_winner", int'(bus.winner), 1);
      wait_until(k + 14); chk("t4_no_run1", int'(bus.state_o), S_DONE);
      fin_force = 0; bus.btn2 = 0;
      chk("t4_drain", exp_q.size(), 0);

      // Start edge mid-run aborts and reloads.
      do_reset();
      start_game(50, k);
      wait_until(k + 6); bus.time_in = 8'd7; bus.start = 1;
      sb_push(EV_LOAD, 7, k + 7);
      wait_until(k + 7);  chk("ab_load", int'(bus.state_o), S_LOAD);
      wait_until(k + 8);  bus.start = 0;
      sb_push(EV_C1, 0, k + 14);
      wait_until(k + 11); chk("ab_run1", int'(bus.state_o), S_RUN1);
      wait_until(k + 15); chk("ab_drain", exp_q.size(), 0);

      // Zero preset is ignored.
      do_reset();
      bus.time_in = '0; bus.start = 1;
      for (int i = 0; i < 3; i++) begin
         step(1);
         chk("t5_idle", int'(bus.state_o), S_IDLE);
      end
      bus.start = 0;
      step(2);
      chk("t5_idle_end", int'(bus.state_o), S_IDLE);

`ifdef CHESS_PAUSE_EN
      // Pause in RUN_P2 for 20 clocks, button ignored, resume into RUN_P2.
      do_reset();
      start_game(50, k);
      wait_until(k + 5);  bus.btn1 = 1;
      sb_push(EV_C2, 0, k + 10);
      wait_until(k + 7);  bus.btn1 = 0;
      wait_until(k + 11); bus.pause = 1;
      wait_until(k + 12); chk("p_pause", int'(bus.state_o), S_PAUSE);
      wait_until(k + 25); bus.btn2 = 1;
      wait_until(k + 26); bus.btn2 = 0;
      wait_until(k + 31); bus.pause = 0;
      wait_until(k + 32); chk("p_still_pause", int'(bus.state_o), S_PAUSE);
      wait_until(k + 33); bus.pause = 1;
      sb_push(EV_C2, 0, k + 37);
      wait_until(k + 34); chk("p_resume", int'(bus.state_o), S_RUN2);
      wait_until(k + 35); bus.pause = 0;
      wait_until(k + 38); chk("p_run2", int'(bus.state_o), S_RUN2);
      chk("p_drain", exp_q.size(), 0);
`endif

      do_reset();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
